// File: rtl/ex_pkg.sv
//------------------------------------------------------------------------------
// Module   : ex_pkg
// Purpose  : Shared ALU function codes, forwarding selects, FSM states and
//            control-bit positions for the multi-cycle execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_pkg;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_MUL = 3'b011;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_SLT = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_t;

  localparam int EX_ALUSRC   = 3;
  localparam int EX_REGDST   = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

endpackage

`default_nettype wire

// File: rtl/ex_stage_mc_mul_iter.sv
//------------------------------------------------------------------------------
// Module   : mul_iter
// Purpose  : Radix-2 shift-add multiplier, one multiplier bit per step;
//            returns the low WIDTH bits of the product.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // Asserted during the step that consumes the final multiplier bit.
  assign last    = step && (cnt == CW'(WIDTH - 1));
  assign product = acc;

endmodule

`default_nettype wire

// File: rtl/ex_stage_mc.sv
//------------------------------------------------------------------------------
// Module   : ex_stage_mc
// Purpose  : Execute stage with operand forwarding, single-cycle ALU, iterative
//            multiply and a stall/flush-aware EX/MEM output register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Valid_In,
  input  logic [WIDTH-1:0]  DataA_In,
  input  logic [WIDTH-1:0]  DataB_In,
  input  logic [WIDTH-1:0]  SE_In,
  input  logic [REG_AW-1:0] Rt_In,
  input  logic [REG_AW-1:0] Rd_In,
  input  logic [3:0]        EXControl_In,
  input  logic [1:0]        MEMControl_In,
  input  logic [1:0]        WBControl_In,
  input  logic [2:0]        Funct_In,
  input  logic [1:0]        FwdA_Sel,
  input  logic [1:0]        FwdB_Sel,
  input  logic [WIDTH-1:0]  FwdMem_In,
  input  logic [WIDTH-1:0]  FwdWb_In,
  input  logic              Stall_In,
  input  logic              Flush_In,
  output logic [WIDTH-1:0]  Result_Out,
  output logic [WIDTH-1:0]  Data_Out,
  output logic [REG_AW-1:0] Rd_Out,
  output logic [1:0]        MEMControl_Out,
  output logic [1:0]        WBControl_Out,
  output logic              Zero_Out,
  output logic              Valid_Out,
  output logic              Busy_Out
);

  ex_state_t         state;
  logic [WIDTH-1:0]  op_a, fwd_b, op_b, alu_res, product;
  logic [REG_AW-1:0] dest_rd;
  logic              is_mul, issue_mul, mul_step, mul_last;
  logic [WIDTH-1:0]  lat_data;
  logic [REG_AW-1:0] lat_rd;
  logic [1:0]        lat_mem, lat_wb;
  logic              unused_aluop;

  assign unused_aluop = ^EXControl_In[2:1];

  always_comb begin
    op_a = DataA_In;
    case (FwdA_Sel)
      FWD_MEM: op_a = FwdMem_In;
      FWD_WB:  op_a = FwdWb_In;
      default: op_a = DataA_In;
    endcase
    fwd_b = DataB_In;
    case (FwdB_Sel)
      FWD_MEM: fwd_b = FwdMem_In;
      FWD_WB:  fwd_b = FwdWb_In;
      default: fwd_b = DataB_In;
    endcase
  end

  assign op_b    = EXControl_In[EX_ALUSRC] ? SE_In : fwd_b;
  assign dest_rd = EXControl_In[EX_REGDST] ? Rd_In : Rt_In;
  assign is_mul  = MUL_EN && (Funct_In == FN_MUL);

  always_comb begin
    alu_res = '0;
    case (Funct_In)
      FN_AND: alu_res = op_a & op_b;
      FN_OR:  alu_res = op_a | op_b;
      FN_ADD: alu_res = op_a + op_b;
      FN_SUB: alu_res = op_a - op_b;
      FN_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      // Without a multiplier the MUL code falls back to ADD.
      FN_MUL: alu_res = MUL_EN ? '0 : (op_a + op_b);
      default: alu_res = '0;
    endcase
  end

  assign issue_mul = (state == ST_IDLE) && Valid_In && is_mul && !Stall_In && !Flush_In;
  assign mul_step  = (state == ST_MUL) && !Stall_In && !Flush_In;
  assign Busy_Out  = (state == ST_MUL);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (issue_mul),
    .step    (mul_step),
    .clear   (Flush_In),
    .a       (op_a),
    .b       (op_b),
    .product (product),
    .last    (mul_last)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= ST_IDLE;
      Result_Out     <= '0;
      Data_Out       <= '0;
      Rd_Out         <= '0;
      MEMControl_Out <= '0;
      WBControl_Out  <= '0;
      Zero_Out       <= 1'b0;
      Valid_Out      <= 1'b0;
      lat_data       <= '0;
      lat_rd         <= '0;
      lat_mem        <= '0;
      lat_wb         <= '0;
    end else if (Flush_In) begin
      state          <= ST_IDLE;
      Result_Out     <= '0;
      Data_Out       <= '0;
      Rd_Out         <= '0;
      MEMControl_Out <= '0;
      WBControl_Out  <= '0;
      Zero_Out       <= 1'b0;
      Valid_Out      <= 1'b0;
    end else if (!Stall_In) begin
      case (state)
        ST_IDLE: begin
          if (Valid_In && !is_mul) begin
            Result_Out     <= alu_res;
            Data_Out       <= fwd_b;
            Rd_Out         <= dest_rd;
            MEMControl_Out <= MEMControl_In;
            WBControl_Out  <= WBControl_In;
            Zero_Out       <= (alu_res == '0);
            Valid_Out      <= 1'b1;
          end else begin
            if (Valid_In) begin
              lat_data <= fwd_b;
              lat_rd   <= dest_rd;
              lat_mem  <= MEMControl_In;
              lat_wb   <= WBControl_In;
              state    <= ST_MUL;
            end
            Result_Out     <= '0;
            Data_Out       <= '0;
            Rd_Out         <= '0;
            MEMControl_Out <= '0;
            WBControl_Out  <= '0;
            Zero_Out       <= 1'b0;
            Valid_Out      <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_last) state <= ST_DONE;
        end
        ST_DONE: begin
          Result_Out     <= product;
          Data_Out       <= lat_data;
          Rd_Out         <= lat_rd;
          MEMControl_Out <= lat_mem;
          WBControl_Out  <= lat_wb;
          Zero_Out       <= (product == '0);
          Valid_Out      <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_stage_mc
// Purpose  : Directed self-checking bench for ex_stage_mc (WIDTH=32).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage_mc;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Valid_In;
  logic [31:0] DataA_In, DataB_In, SE_In, FwdMem_In, FwdWb_In;
  logic [4:0]  Rt_In, Rd_In;
  logic [3:0]  EXControl_In;
  logic [1:0]  MEMControl_In, WBControl_In, FwdA_Sel, FwdB_Sel;
  logic [2:0]  Funct_In;
  logic        Stall_In, Flush_In;
  logic [31:0] Result_Out, Data_Out;
  logic [4:0]  Rd_Out;
  logic [1:0]  MEMControl_Out, WBControl_Out;
  logic        Zero_Out, Valid_Out, Busy_Out;

  int passed = 0;
  int total  = 0;

  ex_stage_mc #(.WIDTH(32), .REG_AW(5), .MUL_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Valid_In(Valid_In),
    .DataA_In(DataA_In), .DataB_In(DataB_In), .SE_In(SE_In),
    .Rt_In(Rt_In), .Rd_In(Rd_In), .EXControl_In(EXControl_In),
    .MEMControl_In(MEMControl_In), .WBControl_In(WBControl_In),
    .Funct_In(Funct_In), .FwdA_Sel(FwdA_Sel), .FwdB_Sel(FwdB_Sel),
    .FwdMem_In(FwdMem_In), .FwdWb_In(FwdWb_In),
    .Stall_In(Stall_In), .Flush_In(Flush_In),
    .Result_Out(Result_Out), .Data_Out(Data_Out), .Rd_Out(Rd_Out),
    .MEMControl_Out(MEMControl_Out), .WBControl_Out(WBControl_Out),
    .Zero_Out(Zero_Out), .Valid_Out(Valid_Out), .Busy_Out(Busy_Out)
  );

  always #5 Clk = ~Clk;

  task automatic clear_inputs;
    Valid_In = 0; DataA_In = 0; DataB_In = 0; SE_In = 0;
    FwdMem_In = 0; FwdWb_In = 0; Rt_In = 0; Rd_In = 0;
    EXControl_In = 0; MEMControl_In = 0; WBControl_In = 0;
    Funct_In = 0; FwdA_Sel = 0; FwdB_Sel = 0; Stall_In = 0; Flush_In = 0;
  endtask

  // Present one instruction at the falling edge, sample after the next rising edge.
  task automatic alu_cycle(input logic [31:0] a, b, se, fm, fw,
                           input logic [2:0] fn, input logic [3:0] ex,
                           input logic [1:0] fa, fb, input logic [4:0] rt, rd);
    @(negedge Clk);
    Valid_In = 1; DataA_In = a; DataB_In = b; SE_In = se;
    FwdMem_In = fm; FwdWb_In = fw; Funct_In = fn; EXControl_In = ex;
    FwdA_Sel = fa; FwdB_Sel = fb; Rt_In = rt; Rd_In = rd;
    MEMControl_In = 2'b00; WBControl_In = 2'b01;
    @(posedge Clk); #1;
  endtask

  task automatic mul_run(input logic [31:0] a, b, input int stall_at, stall_len,
                         output int edges, output int busy_cnt);
    @(negedge Clk);
    Valid_In = 1; DataA_In = a; DataB_In = b; Funct_In = 3'b011;
    EXControl_In = 4'b0001; FwdA_Sel = 0; FwdB_Sel = 0; Rd_In = 5'd7; Rt_In = 5'd2;
    MEMControl_In = 2'b00; WBControl_In = 2'b01; Stall_In = 0; Flush_In = 0;
    edges = 0; busy_cnt = 0;
    while (edges < 60) begin
      @(posedge Clk); #1;
      edges++;
      if (Busy_Out) busy_cnt++;
      if (Valid_Out) break;
      @(negedge Clk);
      Stall_In = (edges >= stall_at) && (edges < stall_at + stall_len);
    end
  endtask

  task automatic test_reset;
    Rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge Clk);
    #1;
    total++; if (Valid_Out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Valid_Out); else passed++;
    total++; if (Result_Out !== 32'h0) $display("FAIL reset_result: got %h expected 0", Result_Out); else passed++;
    total++; if (Busy_Out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy_Out); else passed++;
    total++; if (WBControl_Out !== 2'b00) $display("FAIL reset_wb: got %b expected 00", WBControl_Out); else passed++;
    @(negedge Clk); Rst_n = 1;
  endtask

  task automatic test_add_fwd;
    alu_cycle(32'h99, 32'h5, 32'h0, 32'h10, 32'h0, 3'b010, 4'b0001, 2'b01, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h15) $display("FAIL add_result: got %h expected 15", Result_Out); else passed++;
    total++; if (Valid_Out !== 1'b1) $display("FAIL add_valid: got %b expected 1", Valid_Out); else passed++;
    total++; if (Zero_Out !== 1'b0) $display("FAIL add_zero: got %b expected 0", Zero_Out); else passed++;
    total++; if (Rd_Out !== 5'd3) $display("FAIL add_rd: got %0d expected 3", Rd_Out); else passed++;
    total++; if (WBControl_Out !== 2'b01) $display("FAIL add_wb: got %b expected 01", WBControl_Out); else passed++;
  endtask

  task automatic test_alu_ops;
    alu_cycle(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 3'b111, 4'b0001, 2'b00, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h1) $display("FAIL slt_result: got %h expected 1", Result_Out); else passed++;
    alu_cycle(32'h3, 32'h3, 0, 0, 0, 3'b110, 4'b0001, 2'b00, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h0) $display("FAIL sub_result: got %h expected 0", Result_Out); else passed++;
    total++; if (Zero_Out !== 1'b1) $display("FAIL sub_zero: got %b expected 1", Zero_Out); else passed++;
    // Immediate path: AND uses SE_In, store data still carries register B.
    alu_cycle(32'hF0F0, 32'hFFFF, 32'h0FF0, 0, 0, 3'b000, 4'b1001, 2'b00, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h00F0) $display("FAIL and_imm_result: got %h expected 000000f0", Result_Out); else passed++;
    total++; if (Data_Out !== 32'hFFFF) $display("FAIL and_imm_data: got %h expected 0000ffff", Data_Out); else passed++;
    alu_cycle(32'h100, 32'h77, 0, 0, 32'h3, 3'b001, 4'b0001, 2'b00, 2'b10, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h103) $display("FAIL or_fwdwb_result: got %h expected 103", Result_Out); else passed++;
    alu_cycle(32'h20, 32'h1, 0, 32'h999, 32'h999, 3'b010, 4'b0001, 2'b11, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h21) $display("FAIL fwd_reserved_result: got %h expected 21", Result_Out); else passed++;
    alu_cycle(32'h5, 32'h6, 0, 0, 0, 3'b100, 4'b0001, 2'b00, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h0) $display("FAIL reserved_fn_result: got %h expected 0", Result_Out); else passed++;
    total++; if (Zero_Out !== 1'b1) $display("FAIL reserved_fn_zero: got %b expected 1", Zero_Out); else passed++;
  endtask

  task automatic test_bubble;
    @(negedge Clk);
    clear_inputs();
    MEMControl_In = 2'b01; WBControl_In = 2'b01; Funct_In = 3'b010;
    @(posedge Clk); #1;
    total++; if (Valid_Out !== 1'b0) $display("FAIL bubble_valid: got %b expected 0", Valid_Out); else passed++;
    total++; if (MEMControl_Out !== 2'b00) $display("FAIL bubble_mem: got %b expected 00", MEMControl_Out); else passed++;
    total++; if (WBControl_Out !== 2'b00) $display("FAIL bubble_wb: got %b expected 00", WBControl_Out); else passed++;
  endtask

  task automatic test_stall;
    alu_cycle(32'h0, 32'h5, 0, 32'h10, 0, 3'b010, 4'b0001, 2'b01, 2'b00, 5'd4, 5'd3);
    @(negedge Clk);
    Stall_In = 1; DataA_In = 32'h1234; Funct_In = 3'b110; FwdA_Sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      total++; if (Result_Out !== 32'h15 || Valid_Out !== 1'b1)
        $display("FAIL stall_hold_%0d: got %h/%b expected 15/1", i, Result_Out, Valid_Out);
      else passed++;
    end
    @(negedge Clk);
    clear_inputs();
  endtask

  task automatic test_mul;
    int edges, busy;
    mul_run(32'd7, 32'd6, 1000, 0, edges, busy);
    total++; if (edges !== 34) $display("FAIL mul_latency: got %0d expected 34", edges); else passed++;
    total++; if (busy !== 32) $display("FAIL mul_busy_cycles: got %0d expected 32", busy); else passed++;
    total++; if (Result_Out !== 32'd42) $display("FAIL mul_result: got %0d expected 42", Result_Out); else passed++;
    total++; if (Data_Out !== 32'd6 || Rd_Out !== 5'd7) $display("FAIL mul_data_rd: got %h/%0d expected 6/7", Data_Out, Rd_Out); else passed++;
    @(negedge Clk); Valid_In = 0; Stall_In = 0;
    @(posedge Clk); #1;
    total++; if (Valid_Out !== 1'b0) $display("FAIL mul_valid_pulse: got %b expected 0", Valid_Out); else passed++;
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0, edges, busy);
    total++; if (Result_Out !== 32'h1) $display("FAIL mul_allones: got %h expected 1", Result_Out); else passed++;
    @(negedge Clk); Valid_In = 0;
    mul_run(32'h8000_0001, 32'h3, 1000, 0, edges, busy);
    total++; if (Result_Out !== 32'h8000_0003) $display("FAIL mul_wrap: got %h expected 80000003", Result_Out); else passed++;
    @(negedge Clk); Valid_In = 0;
    mul_run(32'h0001_0000, 32'h0001_0000, 1000, 0, edges, busy);
    total++; if (Result_Out !== 32'h0 || Zero_Out !== 1'b1) $display("FAIL mul_zero: got %h/%b expected 0/1", Result_Out, Zero_Out); else passed++;
    @(negedge Clk); Valid_In = 0;
  endtask

  task automatic test_mul_stall;
    int edges, busy;
    mul_run(32'd7, 32'd6, 5, 3, edges, busy);
    total++; if (edges !== 37) $display("FAIL mul_stall_latency: got %0d expected 37", edges); else passed++;
    total++; if (Result_Out !== 32'd42) $display("FAIL mul_stall_result: got %0d expected 42", Result_Out); else passed++;
    @(negedge Clk); clear_inputs();
  endtask

  task automatic test_flush;
    int late;
    @(negedge Clk);
    Valid_In = 1; DataA_In = 7; DataB_In = 6; Funct_In = 3'b011; EXControl_In = 4'b0001;
    WBControl_In = 2'b01; MEMControl_In = 2'b01;
    repeat (11) @(posedge Clk);
    #1;
    total++; if (Busy_Out !== 1'b1) $display("FAIL flush_pre_busy: got %b expected 1", Busy_Out); else passed++;
    @(negedge Clk);
    Flush_In = 1; Valid_In = 0;
    @(posedge Clk); #1;
    total++; if (Busy_Out !== 1'b0) $display("FAIL flush_busy: got %b expected 0", Busy_Out); else passed++;
    total++; if (Valid_Out !== 1'b0 || WBControl_Out !== 2'b00) $display("FAIL flush_bubble: got %b/%b expected 0/00", Valid_Out, WBControl_Out); else passed++;
    @(negedge Clk); Flush_In = 0;
    alu_cycle(32'h10, 32'h5, 0, 0, 0, 3'b010, 4'b0001, 2'b00, 2'b00, 5'd4, 5'd3);
    total++; if (Result_Out !== 32'h15 || Valid_Out !== 1'b1) $display("FAIL flush_next_add: got %h/%b expected 15/1", Result_Out, Valid_Out); else passed++;
    @(negedge Clk); clear_inputs();
    late = 0;
    repeat (40) begin @(posedge Clk); #1; if (Valid_Out) late++; end
    total++; if (late !== 0) $display("FAIL flush_no_late_result: got %0d valid cycles expected 0", late); else passed++;
  endtask

  task automatic test_reset_mid_mul;
    int late;
    @(negedge Clk);
    Valid_In = 1; DataA_In = 7; DataB_In = 6; Funct_In = 3'b011; EXControl_In = 4'b0001; WBControl_In = 2'b01;
    repeat (12) @(posedge Clk);
    @(negedge Clk); #1;
    total++; if (Busy_Out !== 1'b1) $display("FAIL rstmid_pre_busy: got %b expected 1", Busy_Out); else passed++;
    Rst_n = 0;
    #1;
    total++; if (Busy_Out !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", Busy_Out); else passed++;
    total++; if (Valid_Out !== 1'b0 || Result_Out !== 32'h0 || WBControl_Out !== 2'b00)
      $display("FAIL rstmid_outputs: got %b/%h/%b expected 0/0/00", Valid_Out, Result_Out, WBControl_Out);
    else passed++;
    @(negedge Clk); clear_inputs(); Rst_n = 1;
    late = 0;
    repeat (40) begin @(posedge Clk); #1; if (Valid_Out) late++; end
    total++; if (late !== 0) $display("FAIL rstmid_no_result: got %0d valid cycles expected 0", late); else passed++;
    alu_cycle(32'h1, 32'h2, 0, 0, 0, 3'b010, 4'b0000, 2'b00, 2'b00, 5'd9, 5'd12);
    total++; if (Rd_Out !== 5'd9) $display("FAIL rstmid_rt_dest: got %0d expected 9", Rd_Out); else passed++;
    total++; if (Result_Out !== 32'h3) $display("FAIL rstmid_add: got %h expected 3", Result_Out); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_fwd();
    test_alu_ops();
    test_bubble();
    test_stall();
    test_mul();
    test_mul_stall();
    test_flush();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised successor of the pipeline execute stage.
- Selects forwarded operands and chooses between register and sign-extended immediate.
- Executes single-cycle ALU ops, plus an iterative multi-cycle multiply under an FSM.
- Drives a posedge EX/MEM pipeline register with valid, stall and flush handling. Sits between the ID/EX register and the MEM stage.

Parameters:
- WIDTH, 32, datapath width of operands and result (>=8).
- REG_AW, 5, register-address width for Rt/Rd.
- MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL decodes as ADD.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Valid_In  in  1  ID/EX holds a real instruction.
- DataA_In  in  WIDTH  register operand A.
- DataB_In  in  WIDTH  register operand B.
- SE_In  in  WIDTH  sign-extended immediate.
- Rt_In  in  REG_AW  rt field.
- Rd_In  in  REG_AW  rd field.
- EXControl_In  in  4  [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
- MEMControl_In  in  2  [1] MemRead, [0] MemWrite.
- WBControl_In  in  2  [1] MemToReg, [0] RegWrite.
- Funct_In  in  3  ALU operation code.
- FwdA_Sel  in  2  operand-A source: 00 DataA_In, 01 FwdMem_In, 10 FwdWb_In, 11 reserved (= 00).
- FwdB_Sel  in  2  operand-B source, same encoding, applied before the ALUSrc mux.
- FwdMem_In  in  WIDTH  value forwarded from MEM.
- FwdWb_In  in  WIDTH  value forwarded from WB.
- Stall_In  in  1  downstream hold; freeze stage.
- Flush_In  in  1  kill current/in-flight instruction.
- Result_Out  out  WIDTH  registered ALU result (MEM address).
- Data_Out  out  WIDTH  registered store data (forwarded B, pre-ALUSrc).
- Rd_Out  out  REG_AW  registered destination (RegDst ? Rd : Rt).
- MEMControl_Out  out  2  registered MEM controls.
- WBControl_Out  out  2  registered WB controls.
- Zero_Out  out  1  registered result==0.
- Valid_Out  out  1  output register holds a real instruction.
- Busy_Out  out  1  combinational; multiply in progress, upstream must hold ID/EX.

Behaviour:
- Reset (Rst_n=0, async): all outputs and internal regs 0; FSM=IDLE; Busy_Out=0.
- Funct_In encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB (all mod 2^WIDTH).
  - 111 SLT, signed: result = {WIDTH-1 zeros, A<B}.
  - 011 MUL: low WIDTH bits of A*B.
  - 100, 101 reserved, produce 0.
- Operand B to ALU = ALUSrc ? SE_In : forwarded B.
- FSM states IDLE, MUL, DONE.
- IDLE, Valid_In=1, no stall/flush, non-MUL: output regs load next edge, Valid_Out=1. Latency 1.
- IDLE, Valid_In=1, no stall/flush, MUL: latch operands, Rd, controls; FSM -> MUL; iteration counter = 0. Output regs load a bubble (Valid_Out=0, controls 0).
- MUL: radix-2 shift-add, one bit per cycle; Busy_Out=1. After WIDTH iterations -> DONE.
- DONE: load product and latched Rd/controls into output regs; Valid_Out=1; Busy_Out=0; -> IDLE. Total latency WIDTH+2 edges from issue.
- Valid_In=0 in IDLE: load bubble; Valid_Out=0, MEMControl_Out/WBControl_Out=0.
- Stall_In=1, no flush: output regs, FSM and counter all hold. Busy_Out unchanged.
- Flush_In=1: next edge loads a bubble; FSM -> IDLE; counter cleared; Busy_Out drops that edge. Flush has priority over stall and over DONE.
- Rst_n asserted mid-multiply: immediate return to the reset state; no partial result reaches the outputs.
- Bubbles must never carry MemWrite=1 or RegWrite=1.
- Control inputs are ignored while Busy_Out=1; upstream holds them stable.

Decomposition:
- Package ex_pkg holds:
  - Funct_In codes (FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_MUL);
  - Fwd select codes (FWD_REG, FWD_MEM, FWD_WB);
  - FSM state encoding;
  - control bit-index constants.
- One sub-module, mul_iter: iterative multiplier with start/done handshake, parametrised by WIDTH.

Test Plan:
- ADD, FwdA_Sel=01: FwdMem_In=0x10, DataB_In=0x5, ALUSrc=0, Funct=010 -> next edge Result_Out=0x15, Valid_Out=1, Zero_Out=0.
- SLT signed, Funct=111: A=0xFFFFFFFF, B=1 -> Result_Out=1. Same stimulus with SUB (Funct=110): A=3, B=3 -> Result_Out=0, Zero_Out=1.
- MUL: A=7, B=6, WIDTH=32 -> Busy_Out=1 for 32 cycles, Valid_Out=0 meanwhile, then Result_Out=42, Valid_Out=1 for one cycle.
- Flush at MUL iteration 10 -> next edge Busy_Out=0, Valid_Out=0, WBControl_Out=0; following ADD issues normally.
- Stall_In=1 for 3 cycles after loading result 0x15 -> outputs unchanged. With a MUL in flight, completion is delayed exactly 3 cycles.
- Rst_n pulsed low mid-multiply -> outputs 0 immediately, FSM IDLE; RegDst=0 with Rt=9 after reset -> Rd_Out=9.
